// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake with operand and product bus for booth_multiplier_seq.
interface booth_multiplier_seq_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier (32x32 -> 64 signed) on a 32-bit CLA adder/subtractor.
// Optional MUL_EARLY_TERM_EN: stop as soon as the remaining multiplier bits cannot trigger an add/sub.

// 4-bit carry-lookahead slice with group generate/propagate.
module adder_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_g,
  output logic       o_p
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_s    = w_p ^ w_c;
  assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p    = &w_p;
endmodule

// 32-bit adder/subtractor: Select=0 gives A+B, Select=1 gives A-B.
module adder_subtractor_top (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Select,
  output logic [31:0] Sum,
  output logic        CarryOut
);
  logic [31:0] w_b;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;
  logic [7:0]  w_gc;
  logic        w_cout;

  assign w_b = B ^ {32{Select}};

  for (genvar gi = 0; gi < 8; gi++) begin : g_blk
    adder_cla4 u_cla4 (
      .i_a (A[4*gi +: 4]),
      .i_b (w_b[4*gi +: 4]),
      .i_c (w_gc[gi]),
      .o_s (Sum[4*gi +: 4]),
      .o_g (w_gg[gi]),
      .o_p (w_gp[gi])
    );
  end

  // Group-level carry chain; group G/P depend only on the operands.
  always_comb begin
    logic v_c;
    v_c = Select;
    for (int i = 0; i < 8; i++) begin
      w_gc[i] = v_c;
      v_c     = w_gg[i] | (w_gp[i] & v_c);
    end
    w_cout = v_c;
  end

  assign CarryOut = w_cout;
endmodule

module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_multiplier_seq_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] w_m_nxt;
  logic             r_q_m1;
  logic             w_q_m1_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [PW-1:0]    r_product;
  logic [PW-1:0]    w_product_nxt;

  logic             w_sel;
  logic             w_use_adder;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_s;
  logic [WIDTH-1:0] w_r;
  logic             w_early;
  logic [PW-1:0]    w_early_prod;

  // Booth pair 10 subtracts, 01 adds; Select follows q[0] for both.
  assign w_sel       = r_q[0];
  assign w_use_adder = r_q[0] ^ r_q_m1;

  adder_subtractor_top u_addsub (
    .A        (r_acc),
    .B        (r_m),
    .Select   (w_sel),
    .Sum      (w_sum),
    .CarryOut (w_carry)
  );

  // Bit 32 of the true sum keeps the sign right when acc -/+ m overflows 32 bits.
  assign w_s = w_use_adder ? (r_acc[WIDTH-1] ^ (r_m[WIDTH-1] ^ w_sel) ^ w_carry)
                           : r_acc[WIDTH-1];
  assign w_r = w_use_adder ? w_sum : r_acc;

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] w_mask;

  // Remaining multiplier bits plus q_m1 all equal: every further step is a pure shift.
  always_comb begin
    w_mask       = (r_cnt >= CW'(WIDTH)) ? '1 : ((WIDTH'(1) << r_cnt) - WIDTH'(1));
    w_early      = (((r_q & w_mask) == w_mask) &&  r_q_m1) ||
                   (((r_q & w_mask) == '0)     && !r_q_m1);
    w_early_prod = PW'($signed({r_acc, r_q}) >>> r_cnt);
  end
`else
  assign w_early      = 1'b0;
  assign w_early_prod = '0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_q_nxt       = r_q;
    w_q_m1_nxt    = r_q_m1;
    w_m_nxt       = r_m;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_acc_nxt   = '0;
          w_q_nxt     = bus.multiplier;
          w_q_m1_nxt  = 1'b0;
          w_m_nxt     = bus.multiplicand;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_early) begin
          w_product_nxt = w_early_prod;
          w_state_nxt   = ST_DONE;
        end else begin
          w_acc_nxt  = {w_s, w_r[WIDTH-1:1]};
          w_q_nxt    = {w_r[0], r_q[WIDTH-1:1]};
          w_q_m1_nxt = r_q[0];
          w_cnt_nxt  = r_cnt - CW'(1);
          if (w_cnt_nxt == '0) begin
            w_product_nxt = {w_acc_nxt, w_q_nxt};
            w_state_nxt   = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_q       <= w_q_nxt;
      r_q_m1    <= w_q_m1_nxt;
      r_m       <= w_m_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench for booth_multiplier_seq: products checked on done, plus latency, hold, reset abort.
module tb_booth_multiplier_seq;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_multiplier_seq_if bus_if ();

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  bit          mon_en  = 1'b0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sb);
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int exp_latency(input logic [31:0] q);
    logic [32:0] ext;
    logic [32:0] sh;
    logic [32:0] ones;
    ext = {q, 1'b0};
    if (EARLY) begin
      for (int j = 0; j < 32; j++) begin
        sh   = ext >> j;
        ones = {33{1'b1}} >> j;
        if (sh == '0 || sh == ones) return j + 1;
      end
    end
    return 32;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n && bus_if.done) begin
      n_done++;
      check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) check("product", bus_if.product, sb_q.pop_front());
    end
  end

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp_p);
    int lat;
    @(negedge clk);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = m;
    bus_if.multiplier   = q;
    sb_q.push_back(exp_p);
    @(posedge clk);
    lat = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 0) begin
        bus_if.start        = 1'b0;
        bus_if.multiplicand = $urandom;
        bus_if.multiplier   = $urandom;
        check({tag, "_busy_run"}, 64'(bus_if.busy), 64'd1);
      end
      if (bus_if.done) begin
        lat = j;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(q)));
    check({tag, "_busy_done"}, 64'(bus_if.busy), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
    check({tag, "_busy_idle"}, 64'(bus_if.busy), 64'd0);
    check({tag, "_hold"}, bus_if.product, exp_p);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    int          exp_dones;
    int          nxt_done;
    int          nxt_acc;
    logic [31:0] cm;
    logic [31:0] cq;
    logic [31:0] rm;
    logic [31:0] rq;

    rst_n               = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.multiplicand = '0;
    bus_if.multiplier   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_product", bus_if.product, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_op("7x6",     32'd7,          32'd6,          64'h0000_0000_0000_002A);
    run_op("m3x5",    32'hFFFF_FFFD,  32'h0000_0005,  64'hFFFF_FFFF_FFFF_FFF1);
    run_op("min_min", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
    run_op("min_max", 32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000);
    run_op("max_max", 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001);
    run_op("min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000);
    run_op("m1_min",  32'hFFFF_FFFF,  32'h8000_0000,  64'h0000_0000_8000_0000);
    run_op("123x0",   32'd123,        32'd0,          64'd0);
    run_op("5xm1",    32'd5,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFB);

    // start held for 40 cycles; operands change mid-run and re-accepts follow IDLE only
    @(negedge clk);
    d0        = n_done;
    exp_dones = 0;
    cm        = 32'd9;
    cq        = 32'd9;
    bus_if.start        = 1'b1;
    bus_if.multiplicand = cm;
    bus_if.multiplier   = cq;
    sb_q.push_back(model(cm, cq));
    nxt_done = exp_latency(cq);
    nxt_acc  = -10;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == nxt_done) begin
        exp_dones++;
        nxt_acc = i + 2;
      end
      if (i == nxt_acc - 1) check("hold_idle_busy", 64'(bus_if.busy), 64'd0);
      if (i == nxt_acc) begin
        check("hold_reaccept_busy", 64'(bus_if.busy), 64'd1);
        sb_q.push_back(model(cm, cq));
        nxt_done = i + exp_latency(cq);
      end
      if (i == 5) begin
        cm = 32'd2;
        cq = 32'd2;
        bus_if.multiplicand = cm;
        bus_if.multiplier   = cq;
      end
      if (i == 39) bus_if.start = 1'b0;
    end
    check("hold_done_count", 64'(n_done - d0), 64'(exp_dones));
    for (int j = 0; j < 100 && sb_q.size() > 0; j++) @(negedge clk);
    check("hold_drain", 64'(sb_q.size()), 64'd0);
    @(negedge clk);

    // reset on RUN cycle 10 aborts the operation
    @(negedge clk);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = 32'd100;
    bus_if.multiplier   = 32'h5555_5555;
    sb_q.push_back(model(32'd100, 32'h5555_5555));
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) bus_if.start = 1'b0;
      if (i == 9) rst_n = 1'b0;
    end
    @(negedge clk);
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
    check("abort_product", bus_if.product, 64'd0);
    sb_q.delete();
    rst_n = 1'b1;
    d0    = n_done;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);

    run_op("4xm4", 32'd4, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF0);

    for (int n = 0; n < 300; n++) begin
      rm = $urandom;
      rq = $urandom;
      if (n % 10 == 0) rq = {{20{rq[31]}}, rq[11:0]};
      run_op("rand", rm, rq, model(rm, rq));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
